spi_slave_core: RTL
===================

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning address/data payload width in bits (range 4..32).
REQ-002 SHALL have parameter TX_WAIT, default 16, meaning the maximum number of cycles READ_DATA waits for tx_valid before aborting.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port MOSI, input, 1 bit: serial data from master, sampled on clk rising edge.
REQ-006 SHALL have port SS_n, input, 1 bit: active-low slave select; frame exists only while low.
REQ-007 SHALL have port tx_valid, input, 1 bit: memory read data valid.
REQ-008 SHALL have port tx_data, input, DATA_W bits: memory read data.
REQ-009 SHALL have port rx_data, output, DATA_W+2 bits: received {cmd[1:0], payload}.
REQ-010 SHALL have port rx_valid, output, 1 bit: one-cycle strobe qualifying rx_data.
REQ-011 SHALL have port MISO, output, 1 bit: serial read data to master, MSB first.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle strobe on aborted frame.

Function
REQ-013 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-014 IDLE: SS_n low -> CHK_CMD next cycle; otherwise stay.
REQ-015 CHK_CMD: samples first bit (cmd[1]); MOSI=0 -> WRITE; MOSI=1 and rd_addr_pending=0 -> READ_ADD; MOSI=1 and rd_addr_pending=1 -> READ_DATA.
REQ-016 WRITE/READ_ADD/READ_DATA: shift MOSI into rx shift register MSB first until DATA_W+2 bits total (including CHK_CMD bit); bit counter wraps only via reset or IDLE.
REQ-017 rx_data and rx_valid=1 SHALL be presented in the cycle after the final bit is sampled; rx_valid high exactly one cycle; rx_data holds value until the next strobe.
REQ-018 rd_addr_pending SHALL set on READ_ADD frame completion and clear on READ_DATA frame completion or timeout.
REQ-019 READ_DATA after rx_valid: wait for tx_valid; on the first cycle tx_valid=1, load tx_data; MISO drives tx_data[DATA_W-1] the next cycle, then one bit per cycle, DATA_W cycles total.
REQ-020 tx_valid outside the READ_DATA wait window SHALL be ignored.
REQ-021 If tx_valid does not arrive within TX_WAIT cycles: frame_err pulse, MISO stays 0, rd_addr_pending clears.
REQ-022 MISO SHALL be 0 whenever not shifting read data.
REQ-023 After a frame completes (rx done, tx done if read), the FSM SHALL remain in state, ignoring MOSI, until SS_n high.
REQ-024 SS_n high in any non-IDLE state -> IDLE next cycle; partial receive discarded, no rx_valid; frame_err pulses if fewer than DATA_W+2 bits received or MISO shift incomplete.
REQ-025 SS_n high on the same cycle as the final bit SHALL still complete the frame (rx_valid asserted), with no frame_err.

Reset
REQ-026 rst low SHALL asynchronously force state=IDLE, rx_data=0, rx_valid=0, MISO=0, frame_err=0, counters=0, rd_addr_pending=0.
REQ-027 Reset mid-frame SHALL abort without any rx_valid or frame_err pulse; operation resumes on the first SS_n low after rst high.

Structure
REQ-028 spi_pkg SHALL hold the state enum, 2-bit command codes (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11) and default widths.
REQ-029 The MISO load/shift logic SHALL be one sub-module spi_tx_shifter (load, shift-enable, count-done); the rest stays flat.

Verification (DATA_W=8)
REQ-030 SS_n low, MOSI 00+0xA5 -> rx_data=10'h0A5, rx_valid single pulse one cycle after the 10th bit.
REQ-031 Frame 10+0x3C, then new frame 11+0x00, tx_valid with tx_data=0x96 3 cycles after rx_valid -> second rx_data=10'h300, MISO serially 1,0,0,1,0,1,1,0.
REQ-032 SS_n high after 5 bits of a write -> no rx_valid, frame_err one pulse, state IDLE next cycle.
REQ-033 READ_DATA with no tx_valid for 16 cycles -> frame_err pulse, MISO=0, next 1x frame decoded as READ_ADD.
REQ-034 rst low during bit 7 of a read-data shift -> all outputs 0 immediately, no strobes; next 01+0xFF frame -> rx_data=10'h1FF.
REQ-035 SS_n high coincident with the 10th bit -> rx_valid asserted, frame_err stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state/command types and default widths for the SPI slave core.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TX_WAIT = 16;

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO parallel-load shifter: loads a word, then presents it MSB first,
// one bit per enabled cycle, for exactly DATA_W cycles.
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] load_data,
  output logic              miso,
  output logic              busy,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] data_reg;
  logic [CNT_W-1:0]  cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (clear) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      data_reg <= load_data;
      cnt_reg  <= CNT_W'(DATA_W);
    end else if (shift_en && busy) begin
      data_reg <= data_reg << 1;
      cnt_reg  <= cnt_reg - 1'b1;
    end
  end

  // cnt_reg holds the number of bits still to be presented, current one included
  assign busy = (cnt_reg != '0);
  assign last = (cnt_reg == CNT_W'(1));
  assign miso = busy & data_reg[DATA_W-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave frame engine: decodes {cmd, payload} frames from MOSI and
// returns memory read data on MISO for read-data frames.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TX_WAIT = DEF_TX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int WAIT_W  = $clog2(TX_WAIT + 1);

  spi_state_e state_reg, state_next;

  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [FRAME_W-2:0] rx_sreg_reg;
  logic [FRAME_W-1:0] rx_data_reg;
  logic               rx_valid_reg;
  logic               frame_err_reg;
  logic               rd_addr_pending_reg;
  logic               tx_done_reg;

  logic rx_done, shifting, rx_last, sample, window;
  logic tx_load, timeout, tx_fin, err_next;
  logic tx_busy, tx_last, tx_shift_en;

  always_comb begin
    rx_done     = (bit_cnt_reg == CNT_W'(FRAME_W));
    shifting    = (state_reg inside {WRITE, READ_ADD, READ_DATA}) && !rx_done;
    // The final bit is taken even if SS_n rises in the same cycle
    rx_last     = shifting && (bit_cnt_reg == CNT_W'(FRAME_W - 1));
    sample      = ((state_reg == CHK_CMD || shifting) && !SS_n) || rx_last;
    window      = (state_reg == READ_DATA) && rx_done && !tx_busy && !tx_done_reg && !SS_n;
    tx_load     = window && tx_valid;
    timeout     = window && !tx_valid && (wait_cnt_reg == WAIT_W'(TX_WAIT - 1));
    tx_shift_en = (state_reg == READ_DATA);
    tx_fin      = tx_shift_en && tx_last;
    err_next    = timeout;
    state_next  = state_reg;

    case (state_reg)
      IDLE: begin
        if (!SS_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (!MOSI) begin
          state_next = WRITE;
        end else if (rd_addr_pending_reg) begin
          state_next = READ_DATA;
        end else begin
          state_next = READ_ADD;
        end
      end
      default: begin
        if (SS_n) begin
          state_next = IDLE;
          if (shifting && !rx_last) err_next = 1'b1;
          // Read reply still owed: waiting for tx_valid or mid-shift
          if (state_reg == READ_DATA && rx_done && !tx_done_reg && !tx_last) err_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_reg         <= '0;
      wait_cnt_reg        <= '0;
      rx_sreg_reg         <= '0;
      rx_data_reg         <= '0;
      rx_valid_reg        <= 1'b0;
      frame_err_reg       <= 1'b0;
      rd_addr_pending_reg <= 1'b0;
      tx_done_reg         <= 1'b0;
    end else begin
      rx_valid_reg  <= rx_last;
      frame_err_reg <= err_next;
      if (state_reg == IDLE) begin
        bit_cnt_reg  <= '0;
        wait_cnt_reg <= '0;
        tx_done_reg  <= 1'b0;
      end else begin
        if (sample) begin
          rx_sreg_reg <= {rx_sreg_reg[FRAME_W-3:0], MOSI};
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        if (window && !tx_valid) wait_cnt_reg <= wait_cnt_reg + 1'b1;
        if (timeout || tx_fin)   tx_done_reg  <= 1'b1;
      end
      if (rx_last) rx_data_reg <= {rx_sreg_reg, MOSI};
      if (rx_last && state_reg == READ_ADD) rd_addr_pending_reg <= 1'b1;
      else if (timeout || tx_fin)           rd_addr_pending_reg <= 1'b0;
    end
  end

  spi_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_tx_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear    (SS_n),
    .load     (tx_load),
    .shift_en (tx_shift_en),
    .load_data(tx_data),
    .miso     (MISO),
    .busy     (tx_busy),
    .last     (tx_last)
  );

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;

endmodule
